panel_scan: RTL
===============

# panel_scan

Front-panel matrix scanner that sits between the physical blinkenlights board and the panel logic. It time-multiplexes three 18-bit light rows and two 18-bit switch rows over one shared 18-line column bus. It drives the lamps from the panel's `light0`/`light1`/`light2` words and returns synchronized, optionally debounced switch words `sw0`/`sw1` to the panel.

## Interface
Parameters:
- `DWELL`, 1000, clocks a row is enabled; must be ≥ 3 to cover the 2-flop sync.
- `BLANK`, 16, clocks all rows are off between consecutive rows (anti-ghosting); must be ≥ 1.
- `DB_SCANS`, 4, consecutive differing frame samples needed to accept a switch change; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `light0`, `light1`, `light2`  in  18 each  lamp words, bit 0 = leftmost lamp.
- `col_in`  in  [0:17]  switch sense lines from board; active-low, asynchronous.
- `row`  out  [0:4]  one-hot row enable, active-high; rows 0–2 are lights, rows 3–4 are switches.
- `col_out`  out  [0:17]  lamp drive, active-high.
- `sw0`, `sw1`  out  [0:17]  switch words; `sw0` is row 3, `sw1` is row 4; `col_in[n]` maps to bit n.
- `sw_valid`  out  1  high once switch words reflect real board state.
- `frame`  out  1  one-clock pulse at end of each scan frame.

## Operation
- Two-state FSM per row: BLANK (`BLANK` clocks), then DWELL (`DWELL` clocks), then the row index advances 0→1→2→3→4→0.
- Frame length is 5·(BLANK+DWELL) clocks.
- BLANK state: `row`=0 and `col_out`=0.
- DWELL state: `row[k]`=1.
  - Light rows: `col_out` = snapshot of light k.
  - Switch rows: `col_out`=0.
- Snapshot registers `snap0..2` load `light0..2` on the `frame` cycle. The whole frame therefore shows one coherent set of words, with no tearing.
- `col_in` is inverted, then passed through a 2-flop synchronizer.
- Sample point: last DWELL clock of row 3 (feeds `sw0`) and of row 4 (feeds `sw1`). The sample is the synchronizer output on that clock.
- `frame` is asserted on the last DWELL clock of row 4.
- Reset mid-operation: all state clears immediately (asynchronously). Scanning restarts at row 0 BLANK after `reset_n` rises.

## Timing
- Reset values:
  - `row`=0, `col_out`=0, `sw0`=`sw1`=0, `sw_valid`=0, `frame`=0.
  - Snapshots are 0, so the first frame after reset is dark.
  - FSM state is row 0 BLANK with counter 0.
- `row`/`col_out` are registered. The first DWELL clock of row k begins exactly `BLANK` clocks after the previous row's last DWELL clock.
- A switch word updates on the clock after its sample point.
- `sw_valid` rises:
  - with the macro defined: on the clock after the `DB_SCANS`-th `frame`;
  - without the macro: on the clock after the first `frame`.
  - It stays high until reset.
- Simultaneous light input change and `frame`: the value present on the `frame` clock is captured.

## Configuration
- `PANEL_DEBOUNCE_EN` defined: each switch bit has a saturating counter of width clog2(`DB_SCANS`+1).
  - Sample equals current output bit: counter clears.
  - Sample differs: counter increments.
  - Sample differs and counter = `DB_SCANS`−1: the output bit toggles and the counter clears.
  - A glitch lasting fewer than `DB_SCANS` frames never reaches `sw0`/`sw1`.
- Not defined: the sample is written directly to `sw0`/`sw1`, and no counters are instantiated.

## Structure
- Package `panel_pkg`:
  - `NROWS`=5, `NCOLS`=18;
  - row index constants `ROW_L0`..`ROW_L2`, `ROW_SW0`, `ROW_SW1`;
  - FSM state enum {`ST_BLANK`, `ST_DWELL`}.
- Sub-module `panel_debounce`: 18-bit wide, with `DB_SCANS` parameter and ports sample, sample_en, out. Instantiated twice, once per switch row. When the macro is undefined it reduces to a register.
- Top level holds the FSM, dwell counter, synchronizer and snapshots.

## Test plan
Bench parameters: `DWELL`=4, `BLANK`=2, `DB_SCANS`=3 (frame = 30 clocks).
- Reset, then hold `light1`=18'o252525 for 2 frames. Frame 1: `col_out` stays 0 in all light rows. Frame 2: during row 1 DWELL, `row`=5'b01000 and `col_out`=18'o252525 for exactly 4 clocks, with 2 dark clocks on each side.
- Change `light0` mid-frame from 18'o000000 to 18'o777777. The current frame keeps showing the old value; the new value appears from the frame after the next `frame` pulse.
- Drive `col_in`=18'o777770 (switches 15–17 closed) steadily with the macro defined. `sw_valid`=0 until the 3rd `frame`; then `sw0`=`sw1`=18'o000007 and `sw_valid`=1.
- With the macro defined and `sw0`=0 stable, pull `col_in[0]` low during the row 3 sample of one frame only. `sw0` stays 0. Pulling it low for 3 consecutive frames makes `sw0[0]`=1 on the clock after the 3rd row-3 sample.
- Without the macro, the same single-frame glitch appears in `sw0` for exactly one frame. `sw_valid` rises after the first `frame`.
- Assert `reset_n` low during row 2 DWELL. On the same edge, `row`=0, `col_out`=0, `sw0`=`sw1`=0 and `sw_valid`=0. After release, the first row 0 DWELL begins 2 clocks later.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared constants, types and helpers for the front-panel matrix scanner.
package panel_pkg;

    localparam int unsigned NROWS     = 5;
    localparam int unsigned NCOLS     = 18;
    localparam int unsigned ROW_IDX_W = 3;

    localparam logic [ROW_IDX_W-1:0] ROW_L0  = 3'd0;
    localparam logic [ROW_IDX_W-1:0] ROW_L1  = 3'd1;
    localparam logic [ROW_IDX_W-1:0] ROW_L2  = 3'd2;
    localparam logic [ROW_IDX_W-1:0] ROW_SW0 = 3'd3;
    localparam logic [ROW_IDX_W-1:0] ROW_SW1 = 3'd4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    typedef logic [0:NCOLS-1] col_t;
    typedef logic [0:NROWS-1] row_t;

    // One-hot row enable for a row index; out-of-range indices give all-off.
    function automatic row_t row_onehot(input logic [ROW_IDX_W-1:0] idx);
        row_t r;
        r = '0;
        case (idx)
            ROW_L0:  r[0] = 1'b1;
            ROW_L1:  r[1] = 1'b1;
            ROW_L2:  r[2] = 1'b1;
            ROW_SW0: r[3] = 1'b1;
            ROW_SW1: r[4] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/panel_debounce.sv
// Per-bit switch debouncer for one 18-bit switch row.
// With PANEL_DEBOUNCE_EN defined each bit needs DB_SCANS consecutive differing
// samples before it toggles; otherwise the sample is simply registered.
module panel_debounce
    import panel_pkg::*;
#(
    parameter int unsigned DB_SCANS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  col_t sample,
    input  logic sample_en,
    output col_t out
);

    col_t r_out;

`ifdef PANEL_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DB_SCANS + 1);

    logic [CNT_W-1:0] r_cnt [NCOLS];

    // Saturating agreement counters; a bit flips only after a full run of differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
            for (int unsigned i = 0; i < NCOLS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (sample_en) begin
            for (int unsigned i = 0; i < NCOLS; i++) begin
                if (sample[i] == r_out[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DB_SCANS - 1)) begin
                    r_out[i] <= ~r_out[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    // Debounce disabled: the latest frame sample is the switch word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else if (sample_en) begin
            r_out <= sample;
        end
    end

    if (DB_SCANS == 0) begin : g_db_scans_unused
    end
`endif

    assign out = r_out;

endmodule

// File: rtl/panel_scan.sv
// Front-panel matrix scanner: multiplexes three lamp rows and two switch rows
// over one shared column bus. Optional switch debounce via PANEL_DEBOUNCE_EN.
module panel_scan
    import panel_pkg::*;
#(
    parameter int unsigned DWELL    = 1000,
    parameter int unsigned BLANK    = 16,
    parameter int unsigned DB_SCANS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  col_t light0,
    input  col_t light1,
    input  col_t light2,
    input  col_t col_in,
    output row_t row,
    output col_t col_out,
    output col_t sw0,
    output col_t sw1,
    output logic sw_valid,
    output logic frame
);

    localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

`ifdef PANEL_DEBOUNCE_EN
    localparam int unsigned VALID_FRAMES = DB_SCANS;
`else
    localparam int unsigned VALID_FRAMES = 1;
`endif
    localparam int unsigned FC_W = $clog2(VALID_FRAMES + 1);

    state_t                 r_state, w_state_nxt;
    logic [ROW_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;

    row_t                   r_row;
    col_t                   r_col_out;
    logic                   r_frame;
    logic                   r_sw_valid;
    logic [FC_W-1:0]        r_frame_cnt;
    col_t                   r_snap0, r_snap1, r_snap2;
    col_t                   r_sync1, r_sync2;

    row_t                   w_row_nxt;
    col_t                   w_col_nxt;
    logic                   w_frame_nxt;
    logic                   w_last_dwell;
    logic                   w_sample_sw0;
    logic                   w_sample_sw1;

    // Scan FSM state, row index and dwell/blank counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BLANK;
            r_idx   <= ROW_L0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state plus the row/column/frame values that state will display.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_row_nxt    = '0;
        w_col_nxt    = '0;
        w_frame_nxt  = 1'b0;
        w_last_dwell = 1'b0;

        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CNT_W'(BLANK - 1)) begin
                    w_state_nxt = ST_DWELL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DWELL: begin
                if (r_cnt == CNT_W'(DWELL - 1)) begin
                    w_last_dwell = 1'b1;
                    w_state_nxt  = ST_BLANK;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = (r_idx == ROW_SW1) ? ROW_L0 : r_idx + ROW_IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_idx_nxt   = ROW_L0;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_state_nxt == ST_DWELL) begin
            w_row_nxt   = row_onehot(w_idx_nxt);
            w_frame_nxt = (w_idx_nxt == ROW_SW1) && (w_cnt_nxt == CNT_W'(DWELL - 1));
            case (w_idx_nxt)
                ROW_L0:  w_col_nxt = r_snap0;
                ROW_L1:  w_col_nxt = r_snap1;
                ROW_L2:  w_col_nxt = r_snap2;
                default: w_col_nxt = '0;
            endcase
        end
    end

    assign w_sample_sw0 = w_last_dwell && (r_idx == ROW_SW0);
    assign w_sample_sw1 = w_last_dwell && (r_idx == ROW_SW1);

    // Registered row/column drive and end-of-frame pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row     <= '0;
            r_col_out <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_row     <= w_row_nxt;
            r_col_out <= w_col_nxt;
            r_frame   <= w_frame_nxt;
        end
    end

    // Lamp snapshots taken on the frame cycle so a whole frame is coherent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap0 <= '0;
            r_snap1 <= '0;
            r_snap2 <= '0;
        end else if (r_frame) begin
            r_snap0 <= light0;
            r_snap1 <= light1;
            r_snap2 <= light2;
        end
    end

    // Invert the active-low sense lines and bring them into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~col_in;
            r_sync2 <= r_sync1;
        end
    end

    // Switch words become valid after enough frames to settle the debouncers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_valid  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (r_frame && !r_sw_valid) begin
            if (r_frame_cnt == FC_W'(VALID_FRAMES - 1)) begin
                r_sw_valid <= 1'b1;
            end else begin
                r_frame_cnt <= r_frame_cnt + FC_W'(1);
            end
        end
    end

    panel_debounce #(.DB_SCANS(DB_SCANS)) u_db_sw0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample    (r_sync2),
        .sample_en (w_sample_sw0),
        .out       (sw0)
    );

    panel_debounce #(.DB_SCANS(DB_SCANS)) u_db_sw1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample    (r_sync2),
        .sample_en (w_sample_sw1),
        .out       (sw1)
    );

    assign row      = r_row;
    assign col_out  = r_col_out;
    assign frame    = r_frame;
    assign sw_valid = r_sw_valid;

endmodule
